// File: rtl/spi_txfifo_packer_pkg.sv
// spi_txfifo_packer_pkg: TX FIFO sizing, SPIE bit positions and strobe helpers for the SPI interface.
package spi_txfifo_packer_pkg;
    localparam int NWORD_TXFIFO   = 8;
    localparam int NBYTES_TXFIFO  = 4 * NWORD_TXFIFO;
    localparam int CNT_W          = $clog2(NBYTES_TXFIFO) + 1;
    localparam int PTR_W          = $clog2(NBYTES_TXFIFO);
    localparam int SPIE_TXCNT_LSB = 16;
    localparam int SPIE_TXE_BIT   = 15;
    localparam int SPIE_TNF_BIT   = 9;
    localparam int SPIE_TXT_BIT   = 8;

    function automatic logic strb_legal(input logic [3:0] s);
        return s inside {4'b0001, 4'b0011, 4'b0111, 4'b1111};
    endfunction

    function automatic logic [2:0] strb_bytes(input logic [3:0] s);
        return 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
    endfunction
endpackage

// File: rtl/spi_byte_ram.sv
// spi_byte_ram: 32x8 byte RAM, four write lanes at consecutive wrapping addresses, async read.
module spi_byte_ram
    import spi_txfifo_packer_pkg::*;
(
    input  logic             clk_i,
    input  logic [3:0]       we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [7:0]       rdata_o
);
    logic [7:0] mem_q [NBYTES_TXFIFO];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[waddr_i + PTR_W'(i)] <= wdata_i[8*i +: 8];
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/spi_txfifo_packer.sv
// spi_txfifo_packer: byte-granular SPI TX FIFO packing strobed 32-bit pushes into a byte stream.
module spi_txfifo_packer
    import spi_txfifo_packer_pkg::*;
(
    input  logic             S_SYSCLK,
    input  logic             S_RESET,
    input  logic             S_ENABLE,
    input  logic             S_WR,
    input  logic [31:0]      S_WDATA,
    input  logic [3:0]       S_WSTRB,
    input  logic [CNT_W-1:0] S_THRESH,
    output logic             S_BYTE_VALID,
    output logic [7:0]       S_BYTE,
    input  logic             S_BYTE_READY,
    output logic [CNT_W-1:0] S_TXCNT,
    output logic             S_TNF,
    output logic             S_TXE,
    output logic             S_TXT,
    output logic             S_OVF,
    output logic             S_WERR
);
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, werr_q, werr_d;
    logic             legal, fits, push, pop;
    logic [2:0]       n;

    // Free space is judged on the pre-cycle count; a same-cycle pop does not help.
    always_comb begin
        legal  = strb_legal(S_WSTRB);
        n      = strb_bytes(S_WSTRB);
        fits   = ({1'b0, cnt_q} + (CNT_W+1)'(n)) <= (CNT_W+1)'(NBYTES_TXFIFO);
        push   = S_ENABLE && S_WR && legal && fits;
        pop    = S_BYTE_VALID && S_BYTE_READY;
        wr_d   = S_ENABLE ? wr_q + (push ? PTR_W'(n) : '0) : '0;
        rd_d   = S_ENABLE ? rd_q + PTR_W'(pop) : '0;
        cnt_d  = S_ENABLE ? cnt_q + (push ? CNT_W'(n) : '0) - CNT_W'(pop) : '0;
        ovf_d  = S_ENABLE && S_WR && legal && !fits;
        werr_d = S_ENABLE && S_WR && !legal;
    end

    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            werr_q <= werr_d;
        end
    end

    // Legal strobes are contiguous from byte 0, so the strobe doubles as the lane enable.
    spi_byte_ram u_ram (
        .clk_i   (S_SYSCLK),
        .we_i    (push ? S_WSTRB : 4'b0000),
        .waddr_i (wr_q),
        .wdata_i (S_WDATA),
        .raddr_i (rd_q),
        .rdata_o (S_BYTE)
    );

    assign S_BYTE_VALID = S_ENABLE && (cnt_q != '0);
    assign S_TXCNT      = cnt_q;
    assign S_TXE        = cnt_q == '0;
    assign S_TNF        = cnt_q <= CNT_W'(NBYTES_TXFIFO - 4);
    assign S_TXT        = cnt_q <= S_THRESH;
    assign S_OVF        = ovf_q;
    assign S_WERR       = werr_q;
endmodule
